// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard-side transmitter.
//   Frame layout constants, transmit FSM state encoding, and the odd-parity
//   and frame-building helpers used when a scan code is loaded for sending.
package ps2_pkg;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START_BIT  = 1'b0;
  localparam logic PS2_STOP_BIT   = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HIGH = 2'd1,
    TX_LOW  = 2'd2,
    TX_GAP  = 2'd3
  } tx_state_t;

  // PS/2 uses odd parity: the parity bit makes the total count of ones in
  // data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bit 0 of the result is the first bit on the wire (start bit).
  function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] d);
    return {PS2_STOP_BIT, odd_parity(d), d, PS2_START_BIT};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: synchronous FIFO holding scan codes waiting to be sent.
//   clk   : system clock, rising edge
//   clrn  : synchronous active-low reset, clears both pointers
//   push  : write din (ignored while full, so contents stay untouched)
//   pop   : advance the read pointer (ignored while empty)
//   din   : data to write
//   dout  : combinational head of the FIFO
//   full  : 2**FIFO_AW entries stored
//   empty : no entries stored
module ps2_tx_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB tells a wrapped-around (full) FIFO apart from an
  // empty one when the address bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign dout    = mem[rptr[FIFO_AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 device-side (keyboard) transmitter.
//   Queued 8-bit scan codes are serialised into 11-bit frames (start, 8 data
//   LSB first, odd parity, stop) on ps2_clk/ps2_data, with a fixed idle gap
//   between frames.
//   clk      : system clock, rising edge
//   clrn     : synchronous active-low reset (abandons any frame in flight)
//   code     : scan code to enqueue
//   send_n   : active-low write strobe, accepted when full is low
//   ps2_clk  : registered PS/2 clock, idles high
//   ps2_data : registered PS/2 data, idles high
//   busy     : frame or gap in progress, or codes still queued
//   full     : FIFO holds 2**FIFO_AW codes
//   overflow : sticky, a write was attempted while full
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF   = 8,
  parameter int GAP_CYCLES = 32,
  parameter int FIFO_AW    = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] code,
  input  logic       send_n,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam logic [15:0] HALF_LOAD = 16'(CLK_HALF);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES);
  localparam logic [3:0]  LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  tx_state_t                 state, state_nxt;
  logic [15:0]               div_cnt, div_nxt;
  logic [PS2_FRAME_BITS-1:0] shreg, shreg_nxt;
  logic [3:0]                bit_idx, bit_idx_nxt;
  logic                      clk_q, clk_nxt;
  logic                      data_q, data_nxt;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_empty;
  logic [7:0]                fifo_dout;
  logic [PS2_FRAME_BITS-1:0] head_frame;
  logic                      phase_done;

  // A push while full is dropped here and also inside the FIFO; full is the
  // pre-edge value, so a same-edge pop does not make room for it.
  assign fifo_push  = !send_n && !full;
  assign fifo_pop   = (state == TX_IDLE) && !fifo_empty;
  assign head_frame = build_frame(fifo_dout);
  assign phase_done = (div_cnt == 16'd1);

  ps2_tx_fifo #(
    .WIDTH   (8),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (code),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= TX_IDLE;
      div_cnt <= '0;
      shreg   <= '1;
      bit_idx <= '0;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_idx_nxt;
      clk_q   <= clk_nxt;
      data_q  <= data_nxt;
    end
  end

  // The divider is reloaded on every state entry and a phase ends when it
  // reads 1, so each HIGH/LOW phase is exactly CLK_HALF cycles and each gap
  // exactly GAP_CYCLES cycles. Data only changes together with the rising
  // ps2_clk (or at frame start), giving a full half period of setup before
  // the falling edge where the host samples.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    clk_nxt     = clk_q;
    data_nxt    = data_q;

    unique case (state)
      TX_IDLE: begin
        clk_nxt  = 1'b1;
        data_nxt = 1'b1;
        if (!fifo_empty) begin
          shreg_nxt   = head_frame;
          data_nxt    = head_frame[0];
          bit_idx_nxt = '0;
          div_nxt     = HALF_LOAD;
          state_nxt   = TX_HIGH;
        end
      end

      TX_HIGH: begin
        if (phase_done) begin
          clk_nxt   = 1'b0;
          div_nxt   = HALF_LOAD;
          state_nxt = TX_LOW;
        end else begin
          div_nxt = div_cnt - 16'd1;
        end
      end

      TX_LOW: begin
        if (phase_done) begin
          clk_nxt = 1'b1;
          if (bit_idx != LAST_BIT) begin
            bit_idx_nxt = bit_idx + 4'd1;
            shreg_nxt   = {1'b1, shreg[PS2_FRAME_BITS-1:1]};
            data_nxt    = shreg[1];
            div_nxt     = HALF_LOAD;
            state_nxt   = TX_HIGH;
          end else begin
            data_nxt  = 1'b1;
            div_nxt   = GAP_LOAD;
            state_nxt = TX_GAP;
          end
        end else begin
          div_nxt = div_cnt - 16'd1;
        end
      end

      TX_GAP: begin
        if (phase_done) begin
          div_nxt   = '0;
          state_nxt = TX_IDLE;
        end else begin
          div_nxt = div_cnt - 16'd1;
        end
      end

      default: begin
        state_nxt = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      overflow <= 1'b0;
    end else if (!send_n && full) begin
      overflow <= 1'b1;
    end
  end

  assign ps2_clk  = clk_q;
  assign ps2_data = data_q;
  assign busy     = (state != TX_IDLE) || !fifo_empty;

endmodule
